// File: rtl/wshb_if.sv
// Wishbone B4 pipelined-classic bus bundle, 32-bit data, used between the
// frame reader (master) and the SDRAM controller (slave).
interface wshb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, adr, sel, cti, bte, dat_ms,
        input  dat_sm, ack, err
    );

    modport slave (
        input  cyc, stb, we, adr, sel, cti, bte, dat_ms,
        output dat_sm, ack, err
    );
endinterface

// File: rtl/wshb_frame_reader.sv
// Wishbone burst master streaming a frame buffer into the pixel FIFO, paced on
// FIFO fill level. Define FRAME_READER_PATTERN_EN to push an 8x8 checkerboard instead of bus data.
module wshb_frame_reader #(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          BURST_LEN = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        enable,
    wshb_if.master      wshb_ifm,
    input  logic        fifo_almost_full,
    output logic        fifo_write,
    output logic [31:0] fifo_wdata,
    output logic        frame_start
);

    localparam int BW = $clog2(BURST_LEN);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state;
    logic [BW-1:0]   beat;
    logic [15:0]     x;
    logic [15:0]     y;
    logic [31:0]     adr;
    logic            cyc;
    logic            stb;
    logic [2:0]      cti;

    logic            beat_done;
    logic            last_beat;
    logic            end_of_line;
    logic            last_pix;
    logic [31:0]     push_data;

    assign beat_done   = (state == BURST) && (wshb_ifm.ack || wshb_ifm.err);
    assign last_beat   = (beat == BW'(BURST_LEN - 1));
    assign end_of_line = (x == 16'(HDISP - 1));
    assign last_pix    = end_of_line && (y == 16'(VDISP - 1));

`ifdef FRAME_READER_PATTERN_EN
    assign push_data = {8'h00, (x[3] ^ y[3]) ? 24'hFFFFFF : 24'h000000};
`else
    assign push_data = wshb_ifm.dat_sm;
`endif

    // NOTE: every register here, including the FIFO write path, is updated with
    // non-blocking assignments so all of them see the same pre-edge state.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            beat        <= '0;
            x           <= '0;
            y           <= '0;
            adr         <= BASE_ADDR;
            cyc         <= 1'b0;
            stb         <= 1'b0;
            cti         <= 3'b000;
            fifo_write  <= 1'b0;
            fifo_wdata  <= '0;
            frame_start <= 1'b0;
        end else begin
            fifo_write  <= 1'b0;
            frame_start <= 1'b0;

            case (state)
                IDLE: begin
                    if (enable && !fifo_almost_full) begin
                        state <= BURST;
                        cyc   <= 1'b1;
                        stb   <= 1'b1;
                        beat  <= '0;
                        cti   <= 3'b010;
                    end
                end

                BURST: begin
                    if (beat_done) begin
                        // An errored beat still consumes its pixel slot, but pushes black.
                        fifo_write  <= 1'b1;
                        fifo_wdata  <= wshb_ifm.err ? 32'h0 : push_data;
                        frame_start <= (x == 16'd0) && (y == 16'd0);
                        beat        <= beat + 1'b1;

                        if (last_pix) begin
                            x   <= '0;
                            y   <= '0;
                            adr <= BASE_ADDR;
                        end else begin
                            adr <= adr + 32'd4;
                            if (end_of_line) begin
                                x <= '0;
                                y <= y + 16'd1;
                            end else begin
                                x <= x + 16'd1;
                            end
                        end

                        if (last_beat) begin
                            state <= IDLE;
                            cyc   <= 1'b0;
                            stb   <= 1'b0;
                            cti   <= 3'b000;
                        end else if (beat == BW'(BURST_LEN - 2)) begin
                            cti <= 3'b111;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign wshb_ifm.cyc    = cyc;
    assign wshb_ifm.stb    = stb;
    assign wshb_ifm.we     = 1'b0;
    assign wshb_ifm.adr    = adr;
    assign wshb_ifm.sel    = 4'hF;
    assign wshb_ifm.cti    = cti;
    assign wshb_ifm.bte    = 2'b00;
    assign wshb_ifm.dat_ms = 32'h0;

endmodule
